// File: rtl/ex_operand_stage_if.sv
// Handshake and data bundle between decode, the ID/EX operand stage and EX.
// Also carries the MEM/WB forwarding taps and the EX load tag.
interface ex_operand_stage_if #(
    parameter int XLEN     = 64,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [REG_AW-1:0]   in_rs1_idx;
    logic [REG_AW-1:0]   in_rs2_idx;
    logic [XLEN-1:0]     in_rs1_val;
    logic [XLEN-1:0]     in_rs2_val;
    logic [XLEN-1:0]     in_imm;
    logic                in_a_sel;
    logic                in_b_sel;
    logic [ALU_OP_W-1:0] in_alu_op;
    logic [REG_AW-1:0]   in_rd;
    logic                in_we;
    logic                in_is_load;

    logic                mem_fwd_valid;
    logic [REG_AW-1:0]   mem_fwd_rd;
    logic [XLEN-1:0]     mem_fwd_data;
    logic                wb_fwd_valid;
    logic [REG_AW-1:0]   wb_fwd_rd;
    logic [XLEN-1:0]     wb_fwd_data;
    logic                ex_load_valid;
    logic [REG_AW-1:0]   ex_load_rd;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_a;
    logic [XLEN-1:0]     out_b;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [REG_AW-1:0]   out_rd;
    logic                out_we;
    logic                out_is_load;
    logic [XLEN-1:0]     out_store_data;

    modport master (
        output in_valid, in_pc, in_rs1_idx, in_rs2_idx,
        output in_rs1_val, in_rs2_val, in_imm,
        output in_a_sel, in_b_sel, in_alu_op,
        output in_rd, in_we, in_is_load,
        output mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
        output wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
        output ex_load_valid, ex_load_rd,
        output out_ready,
        input  in_ready,
        input  out_valid, out_a, out_b, out_alu_op,
        input  out_rd, out_we, out_is_load, out_store_data
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_idx, in_rs2_idx,
        input  in_rs1_val, in_rs2_val, in_imm,
        input  in_a_sel, in_b_sel, in_alu_op,
        input  in_rd, in_we, in_is_load,
        input  mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
        input  wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
        input  ex_load_valid, ex_load_rd,
        input  out_ready,
        output in_ready,
        output out_valid, out_a, out_b, out_alu_op,
        output out_rd, out_we, out_is_load, out_store_data
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX operand register ahead of the RV64 ALU, with MEM/WB forwarding.
// Define EX_OPERAND_STATS_EN to add the fwd_cnt/stall_cnt counters.
module ex_operand_stage #(
    parameter int XLEN     = 64,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    ex_operand_stage_if.slave io
`ifdef EX_OPERAND_STATS_EN
    ,
    output logic [31:0] fwd_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [REG_AW-1:0]   rs1_idx;
        logic [REG_AW-1:0]   rs2_idx;
        logic [XLEN-1:0]     rs1v;
        logic [XLEN-1:0]     rs2v;
        logic [XLEN-1:0]     imm;
        logic                a_sel;
        logic                b_sel;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0]   rd;
        logic                we;
        logic                is_load;
    } held_t;

    held_t pl_q, pl_d;
    logic  valid_q, valid_d;
    logic  hz, rdy, cap;

    function automatic logic fwd_hit(input logic [REG_AW-1:0] idx);
        return (idx != '0) &&
               ((io.mem_fwd_valid && io.mem_fwd_rd == idx) ||
                (io.wb_fwd_valid && io.wb_fwd_rd == idx));
    endfunction

    // x0 reads as zero even if a producer claims to write it
    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_AW-1:0] idx,
        input logic [XLEN-1:0]   raw
    );
        if (idx == '0)
            return '0;
        if (io.mem_fwd_valid && io.mem_fwd_rd == idx)
            return io.mem_fwd_data;
        if (io.wb_fwd_valid && io.wb_fwd_rd == idx)
            return io.wb_fwd_data;
        return raw;
    endfunction

    always_comb begin
        hz = io.in_valid && io.ex_load_valid &&
             (io.ex_load_rd != '0) &&
             ((io.in_rs1_idx == io.ex_load_rd && !io.in_a_sel) ||
              (io.in_rs2_idx == io.ex_load_rd));
        rdy = !hz && (!valid_q || io.out_ready) && !flush;
        cap = io.in_valid && rdy;
        pl_d    = pl_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (cap) begin
            pl_d.pc      = io.in_pc;
            pl_d.rs1_idx = io.in_rs1_idx;
            pl_d.rs2_idx = io.in_rs2_idx;
            pl_d.rs1v    = fwd(io.in_rs1_idx, io.in_rs1_val);
            pl_d.rs2v    = fwd(io.in_rs2_idx, io.in_rs2_val);
            pl_d.imm     = io.in_imm;
            pl_d.a_sel   = io.in_a_sel;
            pl_d.b_sel   = io.in_b_sel;
            pl_d.alu_op  = io.in_alu_op;
            pl_d.rd      = io.in_rd;
            pl_d.we      = io.in_we;
            pl_d.is_load = io.in_is_load;
            valid_d      = 1'b1;
        end else if (valid_q && io.out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // keep snooping so results retiring during a stall are not lost
            pl_d.rs1v = fwd(pl_q.rs1_idx, pl_q.rs1v);
            pl_d.rs2v = fwd(pl_q.rs2_idx, pl_q.rs2v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            pl_q    <= pl_d;
            valid_q <= valid_d;
        end
    end

    assign io.in_ready       = rdy;
    assign io.out_valid      = valid_q;
    assign io.out_a          = pl_q.a_sel ? pl_q.pc : pl_q.rs1v;
    assign io.out_b          = pl_q.b_sel ? pl_q.imm : pl_q.rs2v;
    assign io.out_alu_op     = pl_q.alu_op;
    assign io.out_rd         = pl_q.rd;
    assign io.out_we         = pl_q.we;
    assign io.out_is_load    = pl_q.is_load;
    assign io.out_store_data = pl_q.rs2v;

`ifdef EX_OPERAND_STATS_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        h1, h2;

    always_comb begin
        h1 = cap && fwd_hit(io.in_rs1_idx);
        h2 = cap && fwd_hit(io.in_rs2_idx);
        fwd_cnt_d   = fwd_cnt_q + {31'b0, h1} + {31'b0, h2};
        stall_cnt_d = stall_cnt_q + {31'b0, io.in_valid && !rdy};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus a
// randomized run against a transaction-level model of the stage.
module tb_ex_operand_stage;
    localparam int XLEN     = 64;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    ex_operand_stage_if #(
        .XLEN(XLEN), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)
    ) io ();

`ifdef EX_OPERAND_STATS_EN
    logic [31:0] fwd_cnt;
    logic [31:0] stall_cnt;
`endif

    ex_operand_stage #(
        .XLEN(XLEN), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .io(io)
`ifdef EX_OPERAND_STATS_EN
        ,
        .fwd_cnt(fwd_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the instruction sitting in the stage
    logic        m_valid;
    logic [63:0] m_pc, m_imm, m_rs1v, m_rs2v;
    logic [4:0]  m_rs1i, m_rs2i, m_rd, m_op;
    logic        m_asel, m_bsel, m_we, m_ld;
    logic [31:0] m_fwd_cnt, m_stall_cnt;
    logic        exp_rdy, obs_rdy;

    function automatic logic m_hit(input logic [4:0] idx);
        if (idx == 0) return 1'b0;
        if (io.mem_fwd_valid && io.mem_fwd_rd == idx) return 1'b1;
        if (io.wb_fwd_valid && io.wb_fwd_rd == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_fwd(input logic [4:0] idx,
                                          input logic [63:0] raw);
        if (idx == 0) return 64'd0;
        if (io.mem_fwd_valid && io.mem_fwd_rd == idx) return io.mem_fwd_data;
        if (io.wb_fwd_valid && io.wb_fwd_rd == idx) return io.wb_fwd_data;
        return raw;
    endfunction

    function automatic logic [63:0] exp_a();
        return m_asel ? m_pc : m_rs1v;
    endfunction

    function automatic logic [63:0] exp_b();
        return m_bsel ? m_imm : m_rs2v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_imm = 0; m_rs1v = 0; m_rs2v = 0;
        m_rs1i = 0; m_rs2i = 0; m_rd = 0; m_op = 0;
        m_asel = 0; m_bsel = 0; m_we = 0; m_ld = 0;
        m_fwd_cnt = 0; m_stall_cnt = 0;
    endtask

    task automatic idle_inputs();
        flush = 0;
        io.in_valid = 0; io.in_pc = 0; io.in_imm = 0;
        io.in_rs1_idx = 0; io.in_rs2_idx = 0;
        io.in_rs1_val = 0; io.in_rs2_val = 0;
        io.in_a_sel = 0; io.in_b_sel = 0; io.in_alu_op = 0;
        io.in_rd = 0; io.in_we = 0; io.in_is_load = 0;
        io.mem_fwd_valid = 0; io.mem_fwd_rd = 0; io.mem_fwd_data = 0;
        io.wb_fwd_valid = 0; io.wb_fwd_rd = 0; io.wb_fwd_data = 0;
        io.ex_load_valid = 0; io.ex_load_rd = 0;
        io.out_ready = 1;
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [4:0] r1,
                             input logic [63:0] v1, input logic [4:0] r2,
                             input logic [63:0] v2, input logic [63:0] imm,
                             input logic asel, input logic bsel,
                             input logic [4:0] op, input logic [4:0] rd);
        io.in_valid = 1; io.in_pc = pc;
        io.in_rs1_idx = r1; io.in_rs1_val = v1;
        io.in_rs2_idx = r2; io.in_rs2_val = v2;
        io.in_imm = imm; io.in_a_sel = asel; io.in_b_sel = bsel;
        io.in_alu_op = op; io.in_rd = rd;
        io.in_we = 1; io.in_is_load = 0;
    endtask

    // Advance one clock: sample in_ready mid-cycle, step the model at the
    // edge, return 1 time unit after the edge.
    task automatic tick();
        logic hz, cap;
        #2;
        hz = io.in_valid && io.ex_load_valid && io.ex_load_rd != 0 &&
             ((io.in_rs1_idx == io.ex_load_rd && !io.in_a_sel) ||
              io.in_rs2_idx == io.ex_load_rd);
        exp_rdy = !hz && (!m_valid || io.out_ready) && !flush;
        obs_rdy = io.in_ready;
        cap = io.in_valid && exp_rdy;
        if (io.in_valid && !exp_rdy) m_stall_cnt = m_stall_cnt + 1;
        if (cap) m_fwd_cnt = m_fwd_cnt + 32'(m_hit(io.in_rs1_idx))
                                       + 32'(m_hit(io.in_rs2_idx));
        if (flush) begin
            m_valid = 0;
        end else if (cap) begin
            m_valid = 1; m_pc = io.in_pc; m_imm = io.in_imm;
            m_rs1i = io.in_rs1_idx; m_rs2i = io.in_rs2_idx;
            m_rs1v = m_fwd(io.in_rs1_idx, io.in_rs1_val);
            m_rs2v = m_fwd(io.in_rs2_idx, io.in_rs2_val);
            m_asel = io.in_a_sel; m_bsel = io.in_b_sel;
            m_op = io.in_alu_op; m_rd = io.in_rd;
            m_we = io.in_we; m_ld = io.in_is_load;
        end else if (m_valid && io.out_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            m_rs1v = m_fwd(m_rs1i, m_rs1v);
            m_rs2v = m_fwd(m_rs2i, m_rs2v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        model_reset();
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid got %b exp 0", io.out_valid);
        end
        n_checks++;
        if ({io.out_a, io.out_b, io.out_store_data} !== 192'd0 ||
            {io.out_alu_op, io.out_rd, io.out_we, io.out_is_load} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_fields got a=%h b=%h sd=%h exp 0",
                     io.out_a, io.out_b, io.out_store_data);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        // Load an instruction, stall it, then reset between edges
        set_instr(64'h40, 5'd3, 64'h1234, 5'd4, 64'h5678, 0, 0, 0, 5'd1, 5'd9);
        tick();
        io.in_valid = 0; io.out_ready = 0;
        tick();
        n_checks++;
        if (io.out_valid !== 1'b1 || io.out_a !== 64'h1234) begin
            n_errors++;
            $display("FAIL stall_before_rst got v=%b a=%h exp v=1 a=1234",
                     io.out_valid, io.out_a);
        end
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (io.out_valid !== 1'b0 || io.out_a !== 64'd0 ||
            io.out_store_data !== 64'd0) begin
            n_errors++;
            $display("FAIL async_rst got v=%b a=%h sd=%h exp 0",
                     io.out_valid, io.out_a, io.out_store_data);
        end
        model_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_forward_priority();
        set_instr(64'h100, 5'd5, 64'd1, 5'd0, 64'd0, 0, 0, 0, 5'd0, 5'd6);
        io.mem_fwd_valid = 1; io.mem_fwd_rd = 5; io.mem_fwd_data = 64'h10;
        io.wb_fwd_valid = 1; io.wb_fwd_rd = 5; io.wb_fwd_data = 64'h20;
        tick();
        n_checks++;
        if (io.out_valid !== 1'b1 || io.out_a !== 64'h10) begin
            n_errors++;
            $display("FAIL fwd_mem_wins got v=%b a=%h exp v=1 a=10",
                     io.out_valid, io.out_a);
        end
        io.in_rs1_idx = 0;
        io.mem_fwd_rd = 0; io.wb_fwd_rd = 0;
        tick();
        n_checks++;
        if (io.out_a !== 64'd0) begin
            n_errors++;
            $display("FAIL fwd_x0 got a=%h exp 0", io.out_a);
        end
        // WB alone on rs2
        io.mem_fwd_valid = 0;
        io.in_rs2_idx = 5'd8; io.in_rs2_val = 64'h77;
        io.wb_fwd_rd = 5'd8;
        tick();
        n_checks++;
        if (io.out_b !== 64'h20 || io.out_store_data !== 64'h20) begin
            n_errors++;
            $display("FAIL fwd_wb_rs2 got b=%h sd=%h exp 20",
                     io.out_b, io.out_store_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lui();
        set_instr(64'h1000, 5'd0, 0, 5'd0, 0, 64'hFFFFFFFF_80000000,
                  1, 1, 5'd13, 5'd10);
        tick();
        n_checks++;
        if (io.out_a !== 64'h1000 || io.out_b !== 64'hFFFFFFFF_80000000 ||
            io.out_alu_op !== 5'd13 || io.out_rd !== 5'd10) begin
            n_errors++;
            $display("FAIL lui got a=%h b=%h op=%0d rd=%0d exp 1000 ffffffff80000000 13 10",
                     io.out_a, io.out_b, io.out_alu_op, io.out_rd);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        set_instr(64'h200, 5'd1, 64'h11, 5'd7, 64'h22, 0, 0, 0, 5'd2, 5'd3);
        io.ex_load_valid = 1; io.ex_load_rd = 7;
        tick();
        n_checks++;
        if (obs_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL load_use_ready got %b exp 0", obs_rdy);
        end
        n_checks++;
        if (io.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL load_use_bubble got %b exp 0", io.out_valid);
        end
        io.ex_load_valid = 0;
        tick();
        n_checks++;
        if (obs_rdy !== 1'b1 || io.out_valid !== 1'b1 ||
            io.out_store_data !== 64'h22) begin
            n_errors++;
            $display("FAIL load_use_accept got rdy=%b v=%b sd=%h exp 1 1 22",
                     obs_rdy, io.out_valid, io.out_store_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_forward();
        set_instr(64'h300, 5'd9, 64'h111, 5'd0, 0, 0, 0, 0, 5'd4, 5'd5);
        tick();
        io.in_valid = 0; io.out_ready = 0;
        tick();
        io.wb_fwd_valid = 1; io.wb_fwd_rd = 9; io.wb_fwd_data = 64'hABCD;
        tick();
        io.wb_fwd_valid = 0;
        tick();
        n_checks++;
        if (io.out_valid !== 1'b1 || io.out_a !== 64'hABCD) begin
            n_errors++;
            $display("FAIL stall_fwd got v=%b a=%h exp v=1 a=abcd",
                     io.out_valid, io.out_a);
        end
        io.out_ready = 1;
        tick();
        n_checks++;
        if (io.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release got v=%b exp 0", io.out_valid);
        end
    endtask

    task automatic test_flush();
        set_instr(64'h400, 5'd1, 64'h1, 5'd2, 64'h2, 0, 1, 0, 5'd0, 5'd1);
        tick();
        set_instr(64'hDEAD0, 5'd1, 64'h1, 5'd2, 64'h2, 0, 1, 0, 5'd0, 5'd1);
        flush = 1;
        tick();
        n_checks++;
        if (obs_rdy !== 1'b0 || io.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush got rdy=%b v=%b exp 0 0", obs_rdy, io.out_valid);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (io.out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL flush_drop got v=%b a=%h exp v=0",
                         io.out_valid, io.out_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            set_instr(64'h800 + 64'(i * 4), 0, 0, 0, 0, 64'(i), 1, 1, 5'(i), 5'(i));
            tick();
            n_checks++;
            if (io.out_valid !== 1'b1 || io.out_a !== 64'h800 + 64'(i * 4) ||
                io.out_b !== 64'(i)) begin
                n_errors++;
                $display("FAIL b2b[%0d] got v=%b a=%h b=%h exp v=1 a=%h b=%h",
                         i, io.out_valid, io.out_a, io.out_b,
                         64'h800 + 64'(i * 4), 64'(i));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(15) == 0);
            io.in_valid = $urandom_range(3) != 0;
            io.in_pc = {$urandom, $urandom};
            io.in_rs1_idx = 5'($urandom_range(3));
            io.in_rs2_idx = 5'($urandom_range(3));
            io.in_rs1_val = {$urandom, $urandom};
            io.in_rs2_val = {$urandom, $urandom};
            io.in_imm = {$urandom, $urandom};
            io.in_a_sel = 1'($urandom);
            io.in_b_sel = 1'($urandom);
            io.in_alu_op = 5'($urandom);
            io.in_rd = 5'($urandom);
            io.in_we = 1'($urandom);
            io.in_is_load = 1'($urandom);
            io.mem_fwd_valid = 1'($urandom);
            io.mem_fwd_rd = 5'($urandom_range(3));
            io.mem_fwd_data = {$urandom, $urandom};
            io.wb_fwd_valid = 1'($urandom);
            io.wb_fwd_rd = 5'($urandom_range(3));
            io.wb_fwd_data = {$urandom, $urandom};
            io.ex_load_valid = $urandom_range(2) == 0;
            io.ex_load_rd = 5'($urandom_range(3));
            io.out_ready = $urandom_range(3) != 0;
            tick();
            n_checks++;
            if (obs_rdy !== exp_rdy || io.out_valid !== m_valid) begin
                n_errors++;
                $display("FAIL rand_hs[%0d] got rdy=%b v=%b exp rdy=%b v=%b",
                         i, obs_rdy, io.out_valid, exp_rdy, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (io.out_a !== exp_a() || io.out_b !== exp_b() ||
                    io.out_store_data !== m_rs2v || io.out_alu_op !== m_op ||
                    io.out_rd !== m_rd || io.out_we !== m_we ||
                    io.out_is_load !== m_ld) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d] got a=%h b=%h sd=%h exp a=%h b=%h sd=%h",
                             i, io.out_a, io.out_b, io.out_store_data,
                             exp_a(), exp_b(), m_rs2v);
                end
            end
        end
        idle_inputs();
        tick();
`ifdef EX_OPERAND_STATS_EN
        n_checks++;
        if (fwd_cnt !== m_fwd_cnt || stall_cnt !== m_stall_cnt) begin
            n_errors++;
            $display("FAIL stats got fwd=%0d stall=%0d exp fwd=%0d stall=%0d",
                     fwd_cnt, stall_cnt, m_fwd_cnt, m_stall_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_forward_priority();
        test_lui();
        test_load_use();
        test_stall_forward();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
